hpu_reset_dist_pipe: RTL and testbench
======================================

HPU_RESET_DIST_PIPE -- requirements
Module: hpu_reset_dist_pipe

Interface
REQ-001 The block SHALL have parameter INTER_PART_PIPE, default 3: register stages from rst_in to rst_nxt (range 0..16).
REQ-002 The block SHALL have parameter INTRA_PART_PIPE, default 3: register stages from rst_in to rst_out (range 0..16).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all flops sample on its rising edge.
REQ-004 The block SHALL have port rst_in, input, 1 bit: the reset; it is synchronous and active-high, and it is also the value being distributed.
REQ-005 The block SHALL have port rst_nxt, output, 1 bit: active-high reset forwarded to the next device part (SLR).
REQ-006 The block SHALL have port rst_out, output, 1 bit: active-high reset for logic in this part, driven through a global fabric buffer.

Function
REQ-007 rst_nxt SHALL equal rst_in delayed by exactly INTER_PART_PIPE clk cycles, for both assertion and deassertion edges.
REQ-008 rst_out SHALL equal rst_in delayed by exactly INTRA_PART_PIPE clk cycles, for both assertion and deassertion edges.
REQ-009 The two delay chains SHALL be independent shift registers, each fed directly from rst_in; neither chain taps the other.
REQ-010 A chain with zero stages SHALL be a combinational pass-through of rst_in, with no flop.
REQ-011 Each stage SHALL be a plain D flop with no enable and no clear; rst_in is treated as data, not as a clear of the chain.
REQ-012 Every flop in both chains SHALL carry an initial (power-up/configuration) value of 1, so both outputs come up asserted.
REQ-013 The last rst_out stage, or rst_in when INTRA_PART_PIPE=0, SHALL drive a fabric global-buffer primitive whose output is rst_out.
REQ-014 The global-buffer primitive SHALL be modeled as a zero-latency buffer, O = I.
REQ-015 Pulses of any width, including a single cycle, SHALL propagate unfiltered and without width change.
REQ-016 Stage flops SHALL carry keep / no-shift-register-extraction attributes so that each stage can be placed for crossing between parts.
REQ-017 The block SHALL contain no other logic: no synchronizer, no debounce and no polarity inversion.

Reset
REQ-018 No flop SHALL be cleared by rst_in, because the pipeline carries the reset itself.
REQ-019 After power-up, rst_nxt SHALL be 1 until INTER_PART_PIPE edges have sampled rst_in = 0, and the same rule SHALL apply to rst_out with INTRA_PART_PIPE.
REQ-020 Reasserting rst_in while a deassertion is still in flight SHALL simply propagate with the fixed latency; no state is flushed.

Verification
REQ-021 Defaults, power-up with rst_in=0 from cycle 0 -> rst_nxt and rst_out stay 1 for cycles 0-2 and are 0 from cycle 3 onward.
REQ-022 INTER_PART_PIPE=2, INTRA_PART_PIPE=5, drive rst_in 1 for cycles 10-19 -> rst_nxt is 1 for cycles 12-21 and rst_out is 1 for cycles 15-24.
REQ-023 Defaults, a single-cycle rst_in=1 pulse at cycle 20 -> a single-cycle 1 on both outputs at cycle 23.
REQ-024 INTRA_PART_PIPE=0 -> rst_out follows rst_in in the same cycle, combinationally, through the buffer.
REQ-025 Defaults, drive rst_in with the pattern 1,0,1,1,0 -> both outputs reproduce the same pattern exactly, shifted by 3 cycles.
REQ-026 Random rst_in stimulus for 10k cycles -> a scoreboard confirms rst_nxt(t) = rst_in(t-INTER_PART_PIPE) and rst_out(t) = rst_in(t-INTRA_PART_PIPE).

Source files
------------

// File: rtl/hpu_reset_dist_pipe.sv
// Reset distribution pipeline: delays the incoming reset to the next
// device part and, through a global buffer, to logic in this part.

// Zero-latency model of the fabric global-buffer primitive.
module hpu_bufg (
  input  logic I,
  output logic O
);

  assign O = I;

endmodule

module hpu_reset_dist_pipe #(
  parameter int INTER_PART_PIPE = 3,
  parameter int INTRA_PART_PIPE = 3
) (
  input  logic clk,
  input  logic rst_in,
  output logic rst_nxt,
  output logic rst_out
);

  logic w_out_pre;

  // Chain toward the next part; rst_in is data here, never a clear.
  if (INTER_PART_PIPE == 0) begin : g_nxt_comb
    assign rst_nxt = rst_in;
  end else begin : g_nxt_pipe
    (* keep = "true", shreg_extract = "no" *)
    logic [INTER_PART_PIPE:1] r_sr = '1;

    // Plain shift register, powered up asserted.
    always_ff @(posedge clk) begin
      r_sr[1] <= rst_in;
      for (int k = 2; k <= INTER_PART_PIPE; k++)
        r_sr[k] <= r_sr[k-1];
    end

    assign rst_nxt = r_sr[INTER_PART_PIPE];
  end

  // Local chain, fed straight from rst_in, independent of the other.
  if (INTRA_PART_PIPE == 0) begin : g_out_comb
    assign w_out_pre = rst_in;
  end else begin : g_out_pipe
    (* keep = "true", shreg_extract = "no" *)
    logic [INTRA_PART_PIPE:1] r_sr = '1;

    // Plain shift register, powered up asserted.
    always_ff @(posedge clk) begin
      r_sr[1] <= rst_in;
      for (int k = 2; k <= INTRA_PART_PIPE; k++)
        r_sr[k] <= r_sr[k-1];
    end

    assign w_out_pre = r_sr[INTRA_PART_PIPE];
  end

  hpu_bufg u_bufg (
    .I (w_out_pre),
    .O (rst_out)
  );

endmodule

// File: tb/tb_hpu_reset_dist_pipe.sv
// Bench for hpu_reset_dist_pipe: four parameterisations share one
// rst_in; a per-output delay-queue scoreboard predicts every output.
`timescale 1ns/1ps
module tb_hpu_reset_dist_pipe;

  logic clk;
  logic rst_in;
  logic d_nxt, d_out;
  logic a_nxt, a_out;
  logic z_nxt, z_out;
  logic o_nxt, o_out;

  int checks;
  int failures;
  int cyc;

  int    lat [8];
  string nm  [8];
  bit    q   [8][$];

  wire [7:0] w_obs = {o_out, o_nxt, z_out, z_nxt,
                      a_out, a_nxt, d_out, d_nxt};

  hpu_reset_dist_pipe u_def (
    .clk(clk), .rst_in(rst_in), .rst_nxt(d_nxt), .rst_out(d_out));

  hpu_reset_dist_pipe #(.INTER_PART_PIPE(2), .INTRA_PART_PIPE(5)) u_25 (
    .clk(clk), .rst_in(rst_in), .rst_nxt(a_nxt), .rst_out(a_out));

  hpu_reset_dist_pipe #(.INTER_PART_PIPE(0), .INTRA_PART_PIPE(0)) u_z (
    .clk(clk), .rst_in(rst_in), .rst_nxt(z_nxt), .rst_out(z_out));

  hpu_reset_dist_pipe #(.INTER_PART_PIPE(1), .INTRA_PART_PIPE(16)) u_1g (
    .clk(clk), .rst_in(rst_in), .rst_nxt(o_nxt), .rst_out(o_out));

  // Cycle t spans [10t, 10t+10); drive at 10t+1, sample at 10t+6.
  initial begin
    clk = 1'b0;
    #10;
    forever begin
      clk = 1'b1; #5;
      clk = 1'b0; #5;
    end
  end

  // Scoreboard step: record this cycle's input, pop this cycle's expectation.
  task automatic sb_step(input bit v, output bit [7:0] e);
    for (int i = 0; i < 8; i++) begin
      q[i].push_back(v);
      e[i] = q[i].pop_front();
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    bit [7:0] e;
    for (int t = 0; t < 10; t++) begin
      rst_in = 1'b0;
      #5;
      sb_step(1'b0, e);
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (w_obs[i] !== e[i]) begin
          failures++;
          $display("FAIL reset_%s cyc=%0d got=%b exp=%b",
                   nm[i], cyc, w_obs[i], e[i]);
        end
      end
      checks++;
      if (d_nxt !== (cyc < 3) || d_out !== (cyc < 3)) begin
        failures++;
        $display("FAIL reset_default_window cyc=%0d got=%b%b exp=%b",
                 cyc, d_nxt, d_out, (cyc < 3));
      end
      next_cycle();
    end
  endtask

  task automatic test_window();
    bit [7:0] e;
    int base;
    bit v;
    base = cyc;
    for (int t = 0; t < 30; t++) begin
      v = (t >= 10 && t <= 19);
      rst_in = v;
      #5;
      sb_step(v, e);
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (w_obs[i] !== e[i]) begin
          failures++;
          $display("FAIL window_%s cyc=%0d got=%b exp=%b",
                   nm[i], cyc, w_obs[i], e[i]);
        end
      end
      checks++;
      if (a_nxt !== (t >= 12 && t <= 21)) begin
        failures++;
        $display("FAIL window_p2_nxt t=%0d got=%b exp=%b",
                 t, a_nxt, (t >= 12 && t <= 21));
      end
      checks++;
      if (a_out !== (t >= 15 && t <= 24)) begin
        failures++;
        $display("FAIL window_p5_out t=%0d got=%b exp=%b",
                 t, a_out, (t >= 15 && t <= 24));
      end
      next_cycle();
    end
  endtask

  task automatic test_single_pulse();
    bit [7:0] e;
    bit v;
    for (int t = 0; t < 24; t++) begin
      v = (t == 20);
      rst_in = v;
      #5;
      sb_step(v, e);
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (w_obs[i] !== e[i]) begin
          failures++;
          $display("FAIL pulse_%s cyc=%0d got=%b exp=%b",
                   nm[i], cyc, w_obs[i], e[i]);
        end
      end
      checks++;
      if (t >= 3 && (d_nxt !== (t == 23) || d_out !== (t == 23))) begin
        failures++;
        $display("FAIL pulse_default t=%0d got=%b%b exp=%b",
                 t, d_nxt, d_out, (t == 23));
      end
      next_cycle();
    end
  endtask

  task automatic test_pattern();
    bit [7:0] e;
    bit [9:0] pat;
    bit v;
    pat = 10'b0000001101;
    for (int t = 0; t < 10; t++) begin
      v = pat[t];
      rst_in = v;
      #5;
      sb_step(v, e);
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (w_obs[i] !== e[i]) begin
          failures++;
          $display("FAIL pattern_%s cyc=%0d got=%b exp=%b",
                   nm[i], cyc, w_obs[i], e[i]);
        end
      end
      if (t >= 3) begin
        checks++;
        if (d_nxt !== pat[t-3] || d_out !== pat[t-3]) begin
          failures++;
          $display("FAIL pattern_default t=%0d got=%b%b exp=%b",
                   t, d_nxt, d_out, pat[t-3]);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_comb_passthrough();
    bit [7:0] e;
    bit v;
    for (int t = 0; t < 8; t++) begin
      v = t[0] ^ t[2];
      rst_in = v;
      #1;
      checks++;
      if (z_out !== v || z_nxt !== v) begin
        failures++;
        $display("FAIL comb_same_cycle cyc=%0d got=%b%b exp=%b",
                 cyc, z_nxt, z_out, v);
      end
      #4;
      sb_step(v, e);
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (w_obs[i] !== e[i]) begin
          failures++;
          $display("FAIL comb_%s cyc=%0d got=%b exp=%b",
                   nm[i], cyc, w_obs[i], e[i]);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_random();
    bit [7:0] e;
    bit v;
    for (int t = 0; t < 10000; t++) begin
      v = 1'($urandom_range(0, 1));
      rst_in = v;
      #5;
      sb_step(v, e);
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (w_obs[i] !== e[i]) begin
          failures++;
          $display("FAIL random_%s cyc=%0d got=%b exp=%b",
                   nm[i], cyc, w_obs[i], e[i]);
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    rst_in   = 1'b0;
    lat = '{3, 3, 2, 5, 0, 0, 1, 16};
    nm  = '{"def_nxt", "def_out", "p2_nxt", "p5_out",
            "z_nxt", "z_out", "p1_nxt", "p16_out"};
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < lat[i]; k++)
        q[i].push_back(1'b1);
    #1;
    test_reset();
    test_window();
    test_single_pulse();
    test_pattern();
    test_comb_passthrough();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
